// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder controller: one full-adder slice (two half adders + OR) walks the operands LSB first.
// Optional subtract support is compiled in with SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-2:0] res_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    // Operand B and carry-in as loaded on the accepting edge
    logic [WIDTH-1:0] b_load_c;
    logic             cin_load_c;
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load_c   = sub ? ~b : b;
    assign cin_load_c = sub;
`else
    assign b_load_c   = b;
    assign cin_load_c = 1'b0;
`endif

    // Shared slice: first half adder on the operand bits, second folds in the carry
    logic ha0_s_c, ha0_c_c, ha1_s_c, ha1_c_c, cnext_c;
    assign ha0_s_c = a_q[0] ^ b_q[0];
    assign ha0_c_c = a_q[0] & b_q[0];
    assign ha1_s_c = ha0_s_c ^ carry_q;
    assign ha1_c_c = ha0_s_c & carry_q;
    assign cnext_c = ha0_c_c | ha1_c_c;

    // Result with the current sum bit shifted in at the MSB
    logic [WIDTH-1:0] res_d;
    logic             last_c;
    assign res_d  = {ha1_s_c, res_q};
    assign last_c = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_load_c;
                        carry_q <= cin_load_c;
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                        busy    <= 1'b1;
                    end
                end
                S_RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_d[WIDTH-1:1];
                    carry_q <= cnext_c;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_c) begin
                        state_q <= S_DONE;
                        done    <= 1'b1;
                        sum     <= res_d;
                        cout    <= cnext_c;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed testbench for serial_adder_ctrl (WIDTH=8); subtract vectors run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation from IDLE: checks latency, busy span, result and the single done pulse
    task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic sv, input logic [7:0] es, input logic ec);
        int  edges;
        int  busy_cnt;
        bit  seen;
        a = av; b = bv; sub = sv; start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && edges < 40) begin
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
            else begin
                tick();
                edges++;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(edges), 32'(WIDTH));
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        tick();
        chk({tag, "_done_drop"}, 32'(done), 32'd0);
        chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH + 1));
        chk({tag, "_sum_hold"}, 32'(sum), 32'(es));
    endtask

    initial begin
        int  dcount;
        int  last_edge;
        bit  stable;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        tick();

        do_op("add_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
        do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        do_op("add_ff_ff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);
        do_op("add_a5_5a", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0);

        // start pulses during RUN and DONE must be ignored
        a = 8'h10; b = 8'h20; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        a = 8'h01; b = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("busy_start_done", 32'(done), 32'd1);
        chk("busy_start_sum", 32'(sum), 32'h30);
        chk("busy_start_cout", 32'(cout), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_idle", 32'(busy), 32'd0);
        dcount = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (done || busy) dcount++;
        end
        chk("busy_start_no_second", 32'(dcount), 32'd0);

        // reset in the middle of RUN discards the operation
        a = 8'hAA; b = 8'h55; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dcount++;
        end
        chk("midrst_no_done", 32'(dcount), 32'd0);
        do_op("add_22_11", 8'h22, 8'h11, 1'b0, 8'h33, 1'b0);

        // start held high: done every WIDTH+2 cycles, result stable in between
        a = 8'h7F; b = 8'h01; start = 1'b1;
        dcount = 0; last_edge = -1; stable = 1'b1;
        for (int e = 1; e <= 35; e++) begin
            tick();
            if (done) begin
                if (last_edge >= 0) chk("b2b_interval", 32'(e - last_edge), 32'(WIDTH + 2));
                chk("b2b_sum", 32'(sum), 32'h80);
                chk("b2b_cout", 32'(cout), 32'd0);
                last_edge = e;
                dcount++;
            end else if (last_edge >= 0 && (sum !== 8'h80 || cout !== 1'b0)) begin
                stable = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b_pulses", 32'(dcount), 32'd3);
        chk("b2b_stable", 32'(stable), 32'd1);
        dcount = 0;
        while (busy && dcount < 20) begin
            tick();
            dcount++;
        end
        chk("b2b_drain", 32'(busy), 32'd0);
        tick();

`ifdef SERIAL_ADDER_SUB_EN
        do_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
        do_op("sub_09_04", 8'h09, 8'h04, 1'b1, 8'h05, 1'b1);
        do_op("sub0_09_04", 8'h09, 8'h04, 1'b0, 8'h0D, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
